// File: rtl/sync_change_sender_pkg.sv
// Shared types and sizing helpers for the change-driven FIFO write feeder.
package sync_change_sender_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    HOLDOFF = 1'b1
  } state_t;

  // Counter width able to hold values up to n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_refresh_timer.sv
// Idle-interval counter: ticks for one cycle after PERIOD enabled cycles since the last clear.
module sync_refresh_timer
  import sync_change_sender_pkg::*;
#(
  parameter int PERIOD = 100
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = cnt_w(PERIOD);
  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/sync_change_sender.sv
// Mirrors a status word into a shallow CDC FIFO: writes on change, on request or on
// periodic refresh, spaced at least MIN_GAP cycles apart, keeping only the newest value.
module sync_change_sender
  import sync_change_sender_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MIN_GAP     = 8,
  parameter int REFRESH_CYC = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             force_send,
  output logic             write_en,
  output logic [WIDTH-1:0] data_out,
  output logic             pending,
  output logic [7:0]       coalesced_cnt
);

  localparam int GW = cnt_w(MIN_GAP);
  // Loaded on the send edge; IDLE is re-entered MIN_GAP-1 edges later so the next
  // send lands exactly MIN_GAP edges after the previous one.
  localparam logic [GW-1:0] GAP_LOAD = GW'(MIN_GAP - 2);

  state_t           state;
  logic [GW-1:0]    gap_cnt;
  logic [WIDTH-1:0] pend_data;
  logic [WIDTH-1:0] last_sent;
  logic [WIDTH-1:0] ref_val;
  logic             capture;
  logic             send;
  logic             refresh_tick;

  assign ref_val = pending ? pend_data : last_sent;
  assign capture = (data_in != ref_val) || force_send;
  assign send    = (state == IDLE) && pending;

  generate
    if (REFRESH_CYC > 0) begin : g_refresh
      logic refresh_en;
      assign refresh_en = (state == IDLE) && !pending;

      sync_refresh_timer #(
        .PERIOD(REFRESH_CYC)
      ) u_refresh (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (refresh_en),
        .clr    (write_en),
        .tick   (refresh_tick)
      );
    end else begin : g_no_refresh
      assign refresh_tick = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      write_en  <= 1'b0;
      data_out  <= '0;
      last_sent <= '0;
    end else begin
      write_en <= send;
      if (send) begin
        data_out  <= pend_data;
        last_sent <= pend_data;
        state     <= HOLDOFF;
        gap_cnt   <= GAP_LOAD;
      end else if (state == HOLDOFF) begin
        if (gap_cnt == '0) begin
          state <= IDLE;
        end else begin
          gap_cnt <= gap_cnt - GW'(1);
        end
      end
    end
  end

  // A capture in the send cycle re-arms pending with the new word and is not a coalesce.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending       <= 1'b0;
      pend_data     <= '0;
      coalesced_cnt <= '0;
    end else if (capture) begin
      pending   <= 1'b1;
      pend_data <= data_in;
      if (pending && !send && (coalesced_cnt != 8'hFF)) begin
        coalesced_cnt <= coalesced_cnt + 8'd1;
      end
    end else if (send) begin
      pending <= 1'b0;
    end else if (refresh_tick) begin
      pending   <= 1'b1;
      pend_data <= last_sent;
    end
  end

endmodule

// File: tb/tb_sync_change_sender.sv
// Randomized and directed bench for sync_change_sender against a time-based reference model.
module tb_sync_change_sender;

  localparam int WIDTH       = 32;
  localparam int MIN_GAP     = 8;
  localparam int REFRESH_CYC = 100;

  logic             clk;
  logic             reset_n;
  logic [WIDTH-1:0] data_in;
  logic             force_send;
  logic             write_en;
  logic [WIDTH-1:0] data_out;
  logic             pending;
  logic [7:0]       coalesced_cnt;

  sync_change_sender #(
    .WIDTH      (WIDTH),
    .MIN_GAP    (MIN_GAP),
    .REFRESH_CYC(REFRESH_CYC)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .data_in      (data_in),
    .force_send   (force_send),
    .write_en     (write_en),
    .data_out     (data_out),
    .pending      (pending),
    .coalesced_cnt(coalesced_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
  endtask

  // Reference model: edge numbers count from reset release; holdoff is "MIN_GAP edges since
  // the last write", refresh is "REFRESH_CYC eligible idle edges since the last write".
  int          m_e;
  int          m_last_wr;
  int          m_idle;
  logic        m_we;
  logic [31:0] m_dout;
  logic        m_pend;
  logic [31:0] m_pdata;
  logic [31:0] m_last;
  int          m_coal;
  logic [31:0] m_ref;
  bit          m_cap, m_elig, m_send, m_tick;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_e = 0; m_last_wr = -1000; m_idle = 0;
      m_we = 0; m_dout = 0; m_pend = 0; m_pdata = 0; m_last = 0; m_coal = 0;
    end else begin
      m_e++;
      m_ref  = m_pend ? m_pdata : m_last;
      m_cap  = (data_in != m_ref) || force_send;
      m_elig = (m_e - m_last_wr) >= MIN_GAP;
      m_send = m_elig && m_pend;
      m_tick = (REFRESH_CYC > 0) && m_elig && !m_pend && (m_idle == REFRESH_CYC - 1);
      if (m_elig && !m_pend) m_idle = m_tick ? 0 : m_idle + 1;
      m_we = m_send;
      if (m_send) begin
        m_dout = m_pdata; m_last = m_pdata; m_last_wr = m_e; m_idle = 0;
      end
      if (m_cap) begin
        if (m_pend && !m_send && m_coal < 255) m_coal++;
        m_pend = 1; m_pdata = data_in;
      end else if (m_send) begin
        m_pend = 0;
      end else if (m_tick) begin
        m_pend = 1; m_pdata = m_last;
      end
    end
  end

  // Per-cycle compare plus protocol checks on the observed strobes.
  int   dut_wr_cnt;
  int   last_dut_wr;
  bit   have_prev;
  logic prev_we;

  always @(negedge clk) begin
    if (!reset_n) begin
      dut_wr_cnt = 0; have_prev = 0; prev_we = 0;
    end else begin
      check("write_en", {31'd0, write_en}, {31'd0, m_we});
      check("data_out", data_out, m_dout);
      check("pending", {31'd0, pending}, {31'd0, m_pend});
      check("coalesced_cnt", {24'd0, coalesced_cnt}, m_coal);
      if (write_en) begin
        check("no_back_to_back", {31'd0, prev_we}, 32'd0);
        if (have_prev) check("min_gap", {31'd0, (m_e - last_dut_wr) >= MIN_GAP}, 32'd1);
        last_dut_wr = m_e;
        have_prev   = 1;
        dut_wr_cnt++;
      end
      prev_we = write_en;
    end
  end

  // Returns in the cycle following edge k (after outputs settled), inputs safe to drive.
  task automatic wait_edge(input int k);
    while (m_e < k) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [31:0] d);
    @(negedge clk);
    #1;
    reset_n    = 1'b0;
    data_in    = d;
    force_send = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_write_en", {31'd0, write_en}, 32'd0);
    check("rst_data_out", data_out, 32'd0);
    check("rst_pending", {31'd0, pending}, 32'd0);
    check("rst_coalesced", {24'd0, coalesced_cnt}, 32'd0);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    data_in    = '0;
    force_send = 1'b0;

    // Zero input after reset is never sent.
    do_reset(32'h0);
    wait_edge(50);
    check("t1_writes", dut_wr_cnt, 32'd0);
    check("t1_coalesced", {24'd0, coalesced_cnt}, 32'd0);

    // Single change: sampled at edge 10, strobe in cycle 11.
    do_reset(32'h0);
    wait_edge(9);
    data_in = 32'hA5;
    wait_edge(10);
    check("t2_no_early", {31'd0, write_en}, 32'd0);
    wait_edge(11);
    check("t2_we", {31'd0, write_en}, 32'd1);
    check("t2_dout", data_out, 32'hA5);
    wait_edge(40);
    check("t2_writes", dut_wr_cnt, 32'd1);

    // 1,2,3 back to back: 1 at cycle 11, 3 at cycle 19, one coalesce.
    do_reset(32'h0);
    wait_edge(9);  data_in = 32'd1;
    wait_edge(10); data_in = 32'd2;
    wait_edge(11); data_in = 32'd3;
    check("t3_we1", {31'd0, write_en}, 32'd1);
    check("t3_dout1", data_out, 32'd1);
    wait_edge(18);
    check("t3_hold", {31'd0, write_en}, 32'd0);
    wait_edge(19);
    check("t3_we2", {31'd0, write_en}, 32'd1);
    check("t3_dout2", data_out, 32'd3);
    wait_edge(40);
    check("t3_writes", dut_wr_cnt, 32'd2);
    check("t3_coalesced", {24'd0, coalesced_cnt}, 32'd1);

    // force_send inside holdoff (deferred to edge 10) and outside it (one cycle later).
    do_reset(32'h0);
    data_in = 32'h5;
    wait_edge(2);
    check("t4_first", data_out, 32'h5);
    wait_edge(3);  force_send = 1'b1;
    wait_edge(4);  force_send = 1'b0;
    wait_edge(9);
    check("t4_holdoff", {31'd0, write_en}, 32'd0);
    wait_edge(10);
    check("t4_we_hold", {31'd0, write_en}, 32'd1);
    check("t4_dout_hold", data_out, 32'h5);
    wait_edge(20); force_send = 1'b1;
    wait_edge(21); force_send = 1'b0;
    wait_edge(22);
    check("t4_we_free", {31'd0, write_en}, 32'd1);
    wait_edge(30);
    check("t4_writes", dut_wr_cnt, 32'd3);

    // Refresh: counts only idle edges, so resends come MIN_GAP+REFRESH_CYC edges apart.
    do_reset(32'h0);
    data_in = 32'h7;
    wait_edge(109);
    check("t5_before", dut_wr_cnt, 32'd1);
    wait_edge(110);
    check("t5_ref_we", {31'd0, write_en}, 32'd1);
    check("t5_ref_dout", data_out, 32'h7);
    wait_edge(150); data_in = 32'h8;
    wait_edge(152);
    check("t5_chg_we", {31'd0, write_en}, 32'd1);
    check("t5_chg_dout", data_out, 32'h8);
    wait_edge(259);
    check("t5_restart", dut_wr_cnt, 32'd3);
    wait_edge(260);
    check("t5_ref2_we", {31'd0, write_en}, 32'd1);
    check("t5_ref2_dout", data_out, 32'h8);

    // Async reset mid-holdoff with a pending value.
    do_reset(32'h0);
    data_in = 32'h9;
    wait_edge(3);  data_in = 32'hA;
    wait_edge(6);
    check("t6_pre_pending", {31'd0, pending}, 32'd1);
    check("t6_pre_dout", data_out, 32'h9);
    #2 reset_n = 1'b0;
    #1;
    check("t6_async_dout", data_out, 32'h0);
    check("t6_async_pending", {31'd0, pending}, 32'd0);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    wait_edge(2);
    check("t6_resend_we", {31'd0, write_en}, 32'd1);
    check("t6_resend_dout", data_out, 32'hA);
    wait_edge(30);
    check("t6_writes", dut_wr_cnt, 32'd1);

    // Continuous change drives the coalesce counter into saturation.
    do_reset(32'h0);
    for (int i = 1; i <= 400; i++) begin
      data_in = i;
      @(negedge clk);
      #1;
    end
    check("sat_coalesced", {24'd0, coalesced_cnt}, 32'd255);

    // Randomized bursts separated by quiet stretches long enough for refresh.
    do_reset(32'h0);
    for (int seg = 0; seg < 10; seg++) begin
      for (int c = 0; c < 120; c++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 15) data_in = $urandom_range(0, 3);
        else if (r < 20) data_in = $urandom;
        force_send = ($urandom_range(0, 29) == 0);
        @(negedge clk);
        #1;
      end
      force_send = 1'b0;
      repeat (260) begin
        @(negedge clk);
        #1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
